// File: rtl/count_capture_fifo.sv
// count_capture_fifo: first-word-fall-through FIFO of captured counter values,
// with a sticky overflow flag and a saturating count of captures dropped while full.
module count_capture_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         value,
  input  logic                     flag,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [7:0]               drop_count,
  input  logic                     ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic overflow_q, overflow_d;
  logic [7:0] drop_count_q, drop_count_d;
  logic full, pop, push, drop;
  always_comb begin
    full = level_q == FULL_LVL;
    pop = (level_q != '0) && out_ready;
    // a pop frees the slot in the same edge, so a full FIFO still accepts the push
    push = flag && (!full || pop);
    drop = flag && full && !pop;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    overflow_d = drop || (overflow_q && !ovf_clr);
    drop_count_d = ovf_clr ? {7'd0, drop} : drop_count_q + 8'(drop && drop_count_q != 8'hFF);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      overflow_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      overflow_q <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= value;
  end
  assign out_data = mem_q[rd_ptr_q];
  assign out_valid = level_q != '0;
  assign level = level_q;
  assign overflow = overflow_q;
  assign drop_count = drop_count_q;
endmodule

// File: tb/tb_count_capture_fifo.sv
// tb_count_capture_fifo: vector table, directed corner sequences and a random run
// checked against a queue-based model of the capture FIFO.
module tb_count_capture_fifo;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic reset, flag, out_ready, ovf_clr, out_valid, overflow;
  logic [7:0] value, out_data, drop_count;
  logic [3:0] level;
  int checks = 0;
  int failures = 0;
  logic [7:0] mq [$];
  bit m_ovf;
  int m_dc;

  count_capture_fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .value(value), .flag(flag),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .overflow(overflow), .drop_count(drop_count), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst, flg, rdy, clr;
    logic [7:0] val;
    int e_level;
    bit e_valid;
    logic [7:0] e_data;
    bit e_ovf;
    int e_dc;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit flg, input logic [7:0] val, input bit rdy, input bit clr);
    bit do_pop, do_drop;
    @(negedge clk);
    reset = rst; flag = flg; value = val; out_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete(); m_ovf = 0; m_dc = 0;
    end else begin
      do_pop = mq.size() > 0 && rdy;
      do_drop = flg && mq.size() == DEPTH && !do_pop;
      if (do_pop) void'(mq.pop_front());
      if (flg && !do_drop) mq.push_back(val);
      if (clr) begin m_ovf = 0; m_dc = 0; end
      if (do_drop) begin m_ovf = 1; m_dc = (m_dc < 255) ? m_dc + 1 : 255; end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_level"}, int'(level), mq.size());
    chk({tag, "_valid"}, int'(out_valid), int'(mq.size() > 0));
    if (mq.size() > 0) chk({tag, "_data"}, int'(out_data), int'(mq[0]));
    chk({tag, "_ovf"}, int'(overflow), int'(m_ovf));
    chk({tag, "_dc"}, int'(drop_count), m_dc);
  endtask

  initial begin
    vec_t tbl [9];
    logic [7:0] exp_q [$];
    int pct;
    reset = 1; flag = 0; value = 0; out_ready = 0; ovf_clr = 0;
    tbl[0] = '{1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0};
    tbl[1] = '{0, 1, 0, 0, 8'h05, 1, 1, 8'h05, 0, 0};
    tbl[2] = '{0, 1, 0, 0, 8'h06, 2, 1, 8'h05, 0, 0};
    tbl[3] = '{0, 1, 0, 0, 8'h07, 3, 1, 8'h05, 0, 0};
    tbl[4] = '{0, 0, 1, 0, 8'h00, 2, 1, 8'h06, 0, 0};
    tbl[5] = '{0, 0, 1, 0, 8'h00, 1, 1, 8'h07, 0, 0};
    tbl[6] = '{0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0};
    tbl[7] = '{0, 1, 1, 0, 8'h2A, 1, 1, 8'h2A, 0, 0};
    tbl[8] = '{0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0};
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rst, tbl[i].flg, tbl[i].val, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("vec%0d_level", i), int'(level), tbl[i].e_level);
      chk($sformatf("vec%0d_valid", i), int'(out_valid), int'(tbl[i].e_valid));
      if (tbl[i].e_valid) chk($sformatf("vec%0d_data", i), int'(out_data), int'(tbl[i].e_data));
      chk($sformatf("vec%0d_ovf", i), int'(overflow), int'(tbl[i].e_ovf));
      chk($sformatf("vec%0d_dc", i), int'(drop_count), tbl[i].e_dc);
    end

    // overflow while full, then push+pop at full, then drain in order
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 1, 8'(8'h10 + i), 0, 0);
    chk("ovf10_level", int'(level), 8);
    chk("ovf10_ovf", int'(overflow), 1);
    chk("ovf10_dc", int'(drop_count), 2);
    chk("ovf10_head", int'(out_data), 8'h10);
    for (int i = 0; i < 4; i++) drive(0, 1, 8'(8'h20 + i), 1, 0);
    chk("fullpp_level", int'(level), 8);
    chk("fullpp_dc", int'(drop_count), 2);
    chk("fullpp_head", int'(out_data), 8'h14);
    exp_q = '{8'h14, 8'h15, 8'h16, 8'h17, 8'h20, 8'h21, 8'h22, 8'h23};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), int'(out_data), int'(exp_q[i]));
      drive(0, 0, 0, 1, 0);
    end
    chk("drain_valid", int'(out_valid), 0);
    chk("drain_ovf_hold", int'(overflow), 1);

    // streaming through an empty FIFO: level stays 1, data is the previous push
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 8'(8'h40 + i), 1, 0);
      chk($sformatf("stream%0d_level", i), int'(level), 1);
      chk($sformatf("stream%0d_data", i), int'(out_data), 8'h40 + i);
    end
    drive(0, 0, 0, 1, 0);
    chk("stream_empty", int'(out_valid), 0);

    // saturation of drop_count, clear, and clear colliding with a drop
    for (int i = 0; i < 308; i++) drive(0, 1, 8'(i), 0, 0);
    chk("sat_dc", int'(drop_count), 255);
    chk("sat_ovf", int'(overflow), 1);
    drive(0, 0, 0, 0, 1);
    chk("clr_ovf", int'(overflow), 0);
    chk("clr_dc", int'(drop_count), 0);
    chk("clr_level", int'(level), 8);
    chk("clr_head", int'(out_data), 0);
    drive(0, 1, 8'hEE, 0, 1);
    chk("clrdrop_ovf", int'(overflow), 1);
    chk("clrdrop_dc", int'(drop_count), 1);
    chk("clrdrop_level", int'(level), 8);

    // reset mid-stream with a push pending
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 8'(8'h30 + i), 0, 0);
    chk("mid_level", int'(level), 5);
    drive(1, 1, 8'h99, 1, 1);
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    drive(0, 1, 8'h2A, 0, 0);
    chk("post_rst_data", int'(out_data), 8'h2A);
    chk("post_rst_level", int'(level), 1);

    // random traffic against the model, varying consumer speed to reach full and empty
    for (int i = 0; i < 3000; i++) begin
      pct = ((i / 250) % 4) * 30 + 5;
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 60, 8'($urandom),
            $urandom_range(0, 99) < pct, $urandom_range(0, 99) < 3);
      check_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/count_capture_fifo.md
COUNT_CAPTURE_FIFO -- requirements
Module: count_capture_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data width of captured counter value.
REQ-002 Parameter DEPTH, default 8, number of FIFO entries; SHALL be a power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 value  input  WIDTH  counter value from the upstream counter.
REQ-006 flag  input  1  capture strobe from the upstream counter; sampled every cycle.
REQ-007 out_data  output  WIDTH  head-of-FIFO entry; meaningful only while out_valid=1.
REQ-008 out_valid  output  1  FIFO non-empty.
REQ-009 out_ready  input  1  consumer accepts head entry this cycle.
REQ-010 level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-011 overflow  output  1  sticky flag: at least one capture dropped.
REQ-012 drop_count  output  8  number of dropped captures, saturating.
REQ-013 ovf_clr  input  1  clears overflow and drop_count.

Function
REQ-014 Push: every cycle with flag=1 SHALL request a write of value, sampled at that rising edge.
REQ-015 Pop: every cycle with out_valid=1 and out_ready=1 SHALL remove the head entry at that rising edge.
REQ-016 out_ready while out_valid=0 SHALL have no effect.
REQ-017 First-word-fall-through: out_data SHALL equal the oldest entry, registered, with no combinational path from value or flag.
REQ-018 Write-to-output latency: a push into an empty FIFO at edge N SHALL give out_valid=1 and out_data=pushed value after edge N; no same-cycle bypass.
REQ-019 Entries SHALL emerge in push order; write and read pointers wrap modulo DEPTH.
REQ-020 level SHALL be +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
REQ-021 Full (level=DEPTH) with simultaneous push and pop: both SHALL be accepted; level stays DEPTH.
REQ-022 Full with push and no pop: value SHALL be dropped, FIFO contents unchanged, overflow set to 1, drop_count incremented.
REQ-023 drop_count SHALL saturate at 255 and not wrap.
REQ-024 Empty with simultaneous push and out_ready=1: push accepted, no pop; level becomes 1.
REQ-025 overflow and drop_count SHALL hold until ovf_clr or reset.
REQ-026 ovf_clr=1 SHALL zero overflow and drop_count at that edge; a drop in the same cycle SHALL take priority (overflow=1, drop_count=1).
REQ-027 ovf_clr SHALL not affect FIFO contents, pointers, or level.

Reset
REQ-028 reset=1 at a rising edge SHALL force level=0, out_valid=0, overflow=0, drop_count=0, both pointers=0.
REQ-029 reset SHALL take priority over push, pop and ovf_clr in the same cycle; all in-flight entries are discarded.
REQ-030 out_data after reset is don't-care while out_valid=0; storage array need not be reset.
REQ-031 The cycle after reset deasserts, flag=1 SHALL be captured normally.

Verification
REQ-032 Reset, out_ready=0, flag=1 for 3 cycles with value 0x05,0x06,0x07 -> level=3, out_valid=1, out_data=0x05; then out_ready=1 for 3 cycles -> 0x05,0x06,0x07 popped in order, level=0, out_valid=0.
REQ-033 out_ready=0, flag=1 for 10 cycles, value 0x10..0x19 -> level=8, entries 0x10..0x17 retained, overflow=1, drop_count=2.
REQ-034 Full FIFO, flag=1 and out_ready=1 for 4 cycles -> level stays 8, no drop, drop_count unchanged, head advances by 4.
REQ-035 Continuous flag=1, out_ready=1 for 20 cycles from empty -> level toggles 0->1 then holds 1, output sequence equals input sequence delayed one cycle, pointers wrap twice with no loss.
REQ-036 out_ready=0, 300 pushes beyond full -> drop_count=255 saturated; ovf_clr pulse -> overflow=0, drop_count=0, level=8 unchanged.
REQ-037 Reset asserted mid-stream with level=5 and flag=1 -> next cycle level=0, out_valid=0, overflow=0; flag=1 with value 0x2A after release -> out_data=0x2A, level=1.
